// File: rtl/clock_domain_gen.sv
// Per-channel clock generator: run-time divide ratio and polarity, tick strobe,
// one pending configuration slot applied at period boundaries, and global phase align.
module clock_domain_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int CH_W        = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              align_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic              cfg_inv_i,
    output logic [NUM_CH-1:0] clk_out_o,
    output logic [NUM_CH-1:0] tick_o
);

    logic              ready_q, ready_d;
    logic              pend_q, pend_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0]  pend_div_q, pend_div_d;
    logic              pend_inv_q, pend_inv_d;
    logic [NUM_CH-1:0] apply;
    logic              accept;
    logic              ch_ok;
    logic [DIV_W-1:0]  cfg_div_norm;

    assign cfg_div_norm = (cfg_div_i == '0) ? DIV_W'(1) : cfg_div_i;
    assign accept       = cfg_valid_i && ready_q;
    assign ch_ok        = ({1'b0, cfg_ch_i} < (CH_W+1)'(NUM_CH));
    assign cfg_ready_o  = ready_q;

    // Requests to a non-existent channel are consumed without occupying the slot.
    always_comb begin
        ready_d    = ready_q;
        pend_d     = pend_q;
        pend_ch_d  = pend_ch_q;
        pend_div_d = pend_div_q;
        pend_inv_d = pend_inv_q;
        if (|apply) begin
            pend_d  = 1'b0;
            ready_d = 1'b1;
        end else if (accept && ch_ok) begin
            pend_d     = 1'b1;
            ready_d    = 1'b0;
            pend_ch_d  = cfg_ch_i;
            pend_div_d = cfg_div_norm;
            pend_inv_d = cfg_inv_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q    <= 1'b1;
            pend_q     <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
            pend_inv_q <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            pend_q     <= pend_d;
            pend_ch_q  <= pend_ch_d;
            pend_div_q <= pend_div_d;
            pend_inv_q <= pend_inv_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic             inv_q, inv_d;
        logic             out_q, out_d;
        logic             tick_q, tick_d;
        logic [DIV_W:0]   half;
        logic             bypass;
        logic             wrap;
        logic             sel;

        assign half      = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
        assign bypass    = (div_q == DIV_W'(1));
        assign wrap      = ch_en_i[gi] && !bypass && (cnt_q == div_q - DIV_W'(1));
        assign sel       = pend_q && (pend_ch_q == CH_W'(gi));
        assign apply[gi] = sel && (!ch_en_i[gi] || bypass || wrap);

        // Idle and bypass channels sit at phase 0 so the next divided period starts cleanly.
        always_comb begin
            cnt_d  = '0;
            out_d  = 1'b0;
            tick_d = 1'b0;
            div_d  = div_q;
            inv_d  = inv_q;
            if (ch_en_i[gi] && !bypass) begin
                if (align_i) begin
                    out_d  = 1'b1;
                    tick_d = 1'b1;
                end else begin
                    cnt_d  = wrap ? '0 : cnt_q + DIV_W'(1);
                    out_d  = ({1'b0, cnt_q} < half);
                    tick_d = (cnt_q == '0);
                end
            end
            if (apply[gi]) begin
                div_d = pend_div_q;
                inv_d = pend_inv_q;
                if (pend_div_q == DIV_W'(1)) begin
                    out_d  = 1'b0;
                    tick_d = 1'b0;
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q  <= '0;
                div_q  <= DIV_W'(DEFAULT_DIV);
                inv_q  <= 1'b0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                inv_q  <= inv_d;
                out_q  <= out_d;
                tick_q <= tick_d;
            end
        end

        assign clk_out_o[gi] = bypass ? (ch_en_i[gi] ? (clk_i ^ inv_q) : inv_q)
                                      : (out_q ^ inv_q);
        assign tick_o[gi]    = bypass ? ch_en_i[gi] : tick_q;
    end

endmodule
